observer_seq: RTL and testbench
===============================

# observer_seq

Registered, parametrised successor to the combinational four-input observer. It samples NUM_CH input channels of WIDTH bits each on every enabled clock and presents the selected channel through a registered mux. It also flags changes between consecutive samples, reports the lowest changed channel, and keeps a saturating change-event counter. It sits beside the datapath as a non-intrusive debug and monitor block; no downstream logic depends on it for correctness.

## Interface
- NUM_CH, 4, number of observed channels (≥2)
- WIDTH, 1, bits per channel
- CNT_W, 8, event counter width
- SEL_W, $clog2(NUM_CH), select and index width
- Clk  in  1  sole clock, rising edge
- RstN  in  1  asynchronous, active-low reset
- Enable  in  1  observation enable, level-sensitive
- In  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- Sel  in  SEL_W  mux select
- Clear  in  1  synchronous counter clear
- OutMux  out  WIDTH  registered selected-channel sample
- OutChange  out  1  one-cycle pulse: at least one channel differs from the previous sample
- ChangeIdx  out  SEL_W  lowest-numbered channel that changed in the last change event
- OutAllEq  out  1  registered: all channels hold identical values
- EventCount  out  CNT_W  saturating count of OutChange pulses

## Operation
- The FSM has three states: IDLE, ARM and RUN. Reset enters IDLE.
- IDLE transitions:
  - Enable=1 moves to ARM.
  - Otherwise the FSM stays in IDLE. The sample register, OutMux, OutAllEq, ChangeIdx and EventCount hold. OutChange is 0.
- ARM transitions:
  - The FSM captures In into the sample register as the baseline. It updates OutMux and OutAllEq. It does not perform change detection, so OutChange stays 0.
  - Enable=1 moves to RUN. Enable=0 moves to IDLE.
- RUN transitions:
  - Each cycle the FSM compares In with the sample register, per channel. If any channel differs:
    - OutChange=1 on the next cycle.
    - ChangeIdx takes the lowest differing index.
    - EventCount increments.
  - The sample register, OutMux and OutAllEq then update from In.
  - Enable=0 moves to IDLE. The cycle that sees Enable=0 performs no sampling.
- Re-enabling after IDLE always passes through ARM. A change that occurred while disabled is never reported.
- OutMux:
  - Equals the sample of channel Sel. Sel is resampled every cycle, including in IDLE, so Sel changes still show on held data.
  - If Sel ≥ NUM_CH, OutMux=0.
- EventCount:
  - Saturates at 2^CNT_W−1; no wrap-around.
  - Clear=1 forces 0 in any state and has priority over a simultaneous increment.
  - Clear does not affect the other outputs.
- ChangeIdx holds its value between change events.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: In sampled at edge N appears on OutMux/OutAllEq after edge N.
  - OutChange for that comparison is high for exactly the cycle following edge N.
  - EventCount is valid in the same cycle as OutChange.
- Sel→OutMux latency is 1 cycle.
- Reset values: state IDLE; sample register 0; OutMux 0; OutChange 0; ChangeIdx 0; OutAllEq 0; EventCount 0.
- Reset asserted mid-RUN clears everything immediately (asynchronously). After release the FSM is in IDLE and needs an ARM cycle before any change is detected.
- Enable toggling every cycle gives the sequence ARM, IDLE, ARM, … and never produces OutChange.

## Structure
- Shared package observer_pkg:
  - FSM state enum: OBS_IDLE, OBS_ARM, OBS_RUN
  - Helper function for lowest-set-bit index (a priority encoder)
- Natural sub-module: observer_sat_counter (parametrised CNT_W, with inc, clr and saturate). It is reused by later monitor blocks.
- The channel compare, priority encode and mux stay in the top module. The estimated size is roughly 150–200 lines.

## Test plan
- **Reset/idle:** RstN=0, then release with Enable=0 and In=4'b1010 for 5 cycles → all outputs 0, EventCount 0.
- **Arm and mux:** NUM_CH=4, WIDTH=1. Enable=1, In=4'b0100, Sel=2.
  - After 1 cycle (ARM): OutMux=1, OutChange=0.
  - Sel=3: OutMux=0 one cycle later.
  - In=4'b1111: OutAllEq=1.
- **Change detect:** in RUN, In goes from 4'b0000 to 4'b0110 → OutChange is a single-cycle pulse, ChangeIdx=1, EventCount=1. Holding In steady gives no further pulses.
- **Saturation and clear:**
  - CNT_W=3, toggle In[0] every cycle for 10 cycles → EventCount stops at 7.
  - Clear=1 together with a change → EventCount=0, OutChange=1.
- **Disable gap:** RUN with In=4'b0001. Enable=0, In changed to 4'b1000, then Enable=1 → ARM captures 4'b1000 with no OutChange. Next change 4'b1000→4'b1001 gives ChangeIdx=0.
- **Async reset mid-run:** while EventCount=5 and OutChange=1, pulse RstN low between clock edges → outputs go to 0 immediately. After release, the first enabled cycle is ARM and produces no OutChange.

Source files
------------

// File: rtl/observer_pkg.sv
// Shared types and helpers for the observer monitor blocks.
package observer_pkg;

    typedef enum logic [1:0] {
        OBS_IDLE,
        OBS_ARM,
        OBS_RUN
    } obs_state_e;

    // Widest channel vector the priority encoder accepts.
    localparam int unsigned MAX_CH = 32;

    function automatic int unsigned lowest_set(input logic [MAX_CH-1:0] vec);
        int unsigned idx   = 0;
        logic        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/observer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module observer_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/observer_seq.sv
// Registered multi-channel observer: sampled mux, change detection with lowest
// changed index, all-equal flag and a saturating change-event counter.
module observer_seq
    import observer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    clear,
    output logic [WIDTH-1:0]        out_mux,
    output logic                    out_change,
    output logic [SEL_W-1:0]        change_idx,
    output logic                    out_all_eq,
    output logic [CNT_W-1:0]        event_count
);

    obs_state_e                state;
    logic [NUM_CH*WIDTH-1:0]   sample;
    logic [NUM_CH-1:0]         diff;
    logic [MAX_CH-1:0]         diff_ext;
    logic [WIDTH-1:0]          mux_new;
    logic [WIDTH-1:0]          mux_old;
    logic                      eq_new;
    logic                      inc;

    // mux_new selects from the incoming sample, mux_old from the held one.
    always_comb begin
        diff     = '0;
        diff_ext = '0;
        mux_new  = '0;
        mux_old  = '0;
        eq_new   = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            diff[k]     = |(in[k*WIDTH +: WIDTH] ^ sample[k*WIDTH +: WIDTH]);
            diff_ext[k] = diff[k];
            if (in[k*WIDTH +: WIDTH] != in[WIDTH-1:0]) begin
                eq_new = 1'b0;
            end
            if (32'(sel) == k) begin
                mux_new = in[k*WIDTH +: WIDTH];
                mux_old = sample[k*WIDTH +: WIDTH];
            end
        end
    end

    assign inc = (state == OBS_RUN) && enable && (|diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OBS_IDLE;
            sample     <= '0;
            out_mux    <= '0;
            out_change <= 1'b0;
            change_idx <= '0;
            out_all_eq <= 1'b0;
        end else begin
            out_change <= 1'b0;
            unique case (state)
                OBS_IDLE: begin
                    out_mux <= mux_old;
                    if (enable) begin
                        state <= OBS_ARM;
                    end
                end
                // Baseline capture happens even if enable drops this cycle.
                OBS_ARM: begin
                    sample     <= in;
                    out_mux    <= mux_new;
                    out_all_eq <= eq_new;
                    state      <= enable ? OBS_RUN : OBS_IDLE;
                end
                OBS_RUN: begin
                    if (enable) begin
                        out_change <= |diff;
                        if (|diff) begin
                            change_idx <= SEL_W'(lowest_set(diff_ext));
                        end
                        sample     <= in;
                        out_mux    <= mux_new;
                        out_all_eq <= eq_new;
                    end else begin
                        out_mux <= mux_old;
                        state   <= OBS_IDLE;
                    end
                end
                default: state <= OBS_IDLE;
            endcase
        end
    end

    observer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_event_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .clr   (clear),
        .count (event_count)
    );

endmodule

// File: tb/tb_observer_seq.sv
// Scoreboard bench for observer_seq: directed scenarios plus random traffic.
module tb_observer_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] in;
    logic [2:0] sel;
    logic       clear;
    logic [0:0] out_mux;
    logic       out_change;
    logic [2:0] change_idx;
    logic       out_all_eq;
    logic [2:0] event_count;

    observer_seq #(
        .NUM_CH (4),
        .WIDTH  (1),
        .CNT_W  (3),
        .SEL_W  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in          (in),
        .sel         (sel),
        .clear       (clear),
        .out_mux     (out_mux),
        .out_change  (out_change),
        .change_idx  (change_idx),
        .out_all_eq  (out_all_eq),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mux;
        int chg;
        int idx;
        int eq;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: streak counts consecutive enabled edges since the last
    // disabled one; 1 means baseline capture, 2+ means comparing.
    int streak;
    int base[4];
    int m_mux, m_chg, m_idx, m_eq, m_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        streak = 0;
        for (int k = 0; k < 4; k++) base[k] = 0;
        m_mux = 0; m_chg = 0; m_idx = 0; m_eq = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic en, input logic [3:0] i, input logic [2:0] s,
                              input logic c);
        bit   smp   = (streak == 1) || (streak >= 2 && en);
        bit   det   = (streak >= 2) && en;
        bit   found = 0;
        exp_t e;
        m_chg = 0;
        if (det) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(i[k]) != base[k] && !found) begin
                    found = 1;
                    m_idx = k;
                end
            end
            m_chg = found ? 1 : 0;
        end
        if (c) m_cnt = 0;
        else if (found && m_cnt < 7) m_cnt++;
        if (smp) begin
            for (int k = 0; k < 4; k++) base[k] = int'(i[k]);
            m_eq = (i == 4'b0000 || i == 4'b1111) ? 1 : 0;
        end
        m_mux  = (s < 4) ? base[s] : 0;
        streak = en ? ((streak < 2) ? streak + 1 : 2) : 0;
        e.mux = m_mux; e.chg = m_chg; e.idx = m_idx; e.eq = m_eq; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic step(input logic en, input logic [3:0] i, input logic [2:0] s,
                        input logic c);
        enable = en; in = i; sel = s; clear = c;
        @(posedge clk);
        model_edge(en, i, s, c);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("out_mux",     int'(out_mux),     mon_e.mux);
            check("out_change",  int'(out_change),  mon_e.chg);
            check("change_idx",  int'(change_idx),  mon_e.idx);
            check("out_all_eq",  int'(out_all_eq),  mon_e.eq);
            check("event_count", int'(event_count), mon_e.cnt);
        end
    end

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_mux",     int'(out_mux),     0);
        check("rst_out_change",  int'(out_change),  0);
        check("rst_change_idx",  int'(change_idx),  0);
        check("rst_out_all_eq",  int'(out_all_eq),  0);
        check("rst_event_count", int'(event_count), 0);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cur;
        rst_n = 1'b0; enable = 1'b0; in = 4'b1010; sel = 3'd0; clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle: nothing moves while disabled.
        repeat (5) step(1'b0, 4'b1010, 3'd0, 1'b0);

        // Arm and mux.
        step(1'b1, 4'b0100, 3'd2, 1'b0);
        step(1'b1, 4'b0100, 3'd2, 1'b0);
        step(1'b1, 4'b0100, 3'd3, 1'b0);
        step(1'b1, 4'b1111, 3'd3, 1'b0);
        step(1'b1, 4'b1111, 3'd5, 1'b0);

        // Change detect, then steady input.
        step(1'b1, 4'b0000, 3'd1, 1'b0);
        step(1'b1, 4'b0110, 3'd1, 1'b0);
        repeat (3) step(1'b1, 4'b0110, 3'd1, 1'b0);

        // Saturation, then clear colliding with a change.
        cur = 4'b0110;
        for (int n = 0; n < 10; n++) begin
            cur[0] = ~cur[0];
            step(1'b1, cur, 3'd0, 1'b0);
        end
        cur[0] = ~cur[0];
        step(1'b1, cur, 3'd0, 1'b1);

        // Disable gap: change while off is never reported.
        step(1'b1, 4'b0001, 3'd3, 1'b0);
        step(1'b0, 4'b1000, 3'd3, 1'b0);
        step(1'b0, 4'b1000, 3'd3, 1'b0);
        step(1'b1, 4'b1000, 3'd3, 1'b0);
        step(1'b1, 4'b1000, 3'd3, 1'b0);
        step(1'b1, 4'b1001, 3'd0, 1'b0);

        // Enable toggling every cycle never reports a change.
        for (int n = 0; n < 8; n++) step(n[0] ? 1'b0 : 1'b1, 4'(n * 5), 3'd1, 1'b0);

        // Build EventCount=5 with a live pulse, then async reset mid-run.
        step(1'b1, 4'b0000, 3'd0, 1'b0);
        step(1'b1, 4'b0000, 3'd0, 1'b0);
        step(1'b1, 4'b0000, 3'd0, 1'b1);
        cur = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            cur[2] = ~cur[2];
            step(1'b1, cur, 3'd2, 1'b0);
        end
        async_reset_pulse();
        step(1'b1, 4'b1111, 3'd2, 1'b0);
        step(1'b1, 4'b0000, 3'd2, 1'b0);
        step(1'b1, 4'b0011, 3'd2, 1'b0);

        // Random traffic.
        cur = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) cur = 4'($urandom);
            step($urandom_range(0, 9) < 8, cur, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
